// File: rtl/up_down_counter_param.sv
// Up/down counter with programmable modulus, sync load/clear, and a free-run / one-shot FSM.
// Optional step prescaler is built only when COUNTER_PRESCALE_EN is defined.
module up_down_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             one_shot_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             running_o,
    output logic             done_o
);

    if (WIDTH < 2 || MAX_VAL > (2 ** WIDTH) - 1 || RESET_VAL > MAX_VAL || PRESCALE < 1) begin : g_bad_params
        $error("up_down_counter_param: illegal parameter combination");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             running_q, done_q;
    logic             step_c;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    // Phase counter: only advances on enabled RUN cycles, restarts on any disturbance
    always_comb begin
        presc_d = presc_q;
        step_c  = 1'b0;
        if (clear_i || load_i || state_q != ST_RUN) begin
            presc_d = '0;
        end else if (en_i) begin
            if (presc_q == PRESC_LAST) begin
                step_c  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    always_comb begin
        step_c = en_i && (state_q == ST_RUN);
    end
`endif

    // Next state / count: clear > load > start > step
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear_i) begin
            count_d = RST_C;
            state_d = ST_IDLE;
        end else if (load_i) begin
            count_d = (load_val_i > MAX_C) ? MAX_C : load_val_i;
        end else if (start_i && state_q != ST_RUN) begin
            state_d = ST_RUN;
            if (state_q == ST_DONE) begin
                count_d = up_dn_i ? '0 : MAX_C;
            end
        end else if (step_c) begin
            if (up_dn_i ? (count_q == MAX_C) : (count_q == '0)) begin
                tc_d = 1'b1;
                if (one_shot_i) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = up_dn_i ? '0 : MAX_C;
                end
            end else begin
                count_d = up_dn_i ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            count_q   <= RST_C;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign count_o   = count_q;
    assign tc_o      = tc_q;
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Bench for up_down_counter_param (WIDTH=3, MAX_VAL=5): directed spot checks plus
// randomized traffic compared every cycle against a modular-arithmetic reference model.
module tb_up_down_counter_param;

    localparam int W  = 3;
    localparam int M  = 5;
    localparam int RV = 0;
`ifdef COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         one_shot = 1'b0, start = 1'b0;
    logic [W-1:0] count;
    logic         tc, running, done;

    int errors = 0;
    int checks = 0;

    // reference model state: mode 0=idle 1=run 2=done
    int m_count = RV, m_mode = 0, m_tc = 0, m_ps = 0;

    up_down_counter_param #(.WIDTH(W), .MAX_VAL(M), .RESET_VAL(RV), .PRESCALE(4)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .up_dn_i(up_dn), .clear_i(clear),
        .load_i(load), .load_val_i(load_val), .one_shot_i(one_shot), .start_i(start),
        .count_o(count), .tc_o(tc), .running_o(running), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int delta;
        m_tc = 0;
        if (reset) begin
            m_count = RV; m_mode = 0; m_ps = 0;
        end else if (clear) begin
            m_count = RV; m_mode = 0; m_ps = 0;
        end else if (load) begin
            m_count = (int'(load_val) > M) ? M : int'(load_val);
            m_ps = 0;
        end else if (start && m_mode != 1) begin
            if (m_mode == 2) m_count = up_dn ? 0 : M;
            m_mode = 1; m_ps = 0;
        end else if (m_mode == 1 && en) begin
            m_ps++;
            if (m_ps == PS) begin
                m_ps = 0;
                m_tc = up_dn ? (m_count == M) : (m_count == 0);
                if (m_tc && one_shot) begin
                    m_mode = 2;
                end else begin
                    delta   = up_dn ? 1 : M;
                    m_count = (m_count + delta) % (M + 1);
                end
            end
        end
    endtask

    // Every cycle: advance the model on the edge, compare just after it
    always @(posedge clk) begin
        model_edge();
        #1;
        chk("count", int'(count), m_count);
        chk("tc", int'(tc), m_tc);
        chk("running", int'(running), int'(m_mode == 1));
        chk("done", int'(done), int'(m_mode == 2));
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        en = 1'b1;
        repeat (n * PS) cyc();
        en = 1'b0;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int exp_seq[4];
        cyc(); cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        cyc();

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_running", int'(running), 1);
        chk("start_count", int'(count), 0);

        // free-run up wrap
        for (int k = 1; k <= 6; k++) begin
            steps(1);
            chk("up_count", int'(count), k % 6);
            chk("up_tc", int'(tc), int'(k == 6));
        end

        // free-run down from 2
        do_load(2);
        chk("load2_count", int'(count), 2);
        chk("load2_running", int'(running), 1);
        up_dn = 1'b0;
        exp_seq = '{1, 0, 5, 4};
        for (int k = 0; k < 4; k++) begin
            steps(1);
            chk("dn_count", int'(count), exp_seq[k]);
            chk("dn_tc", int'(tc), int'(k == 2));
        end

        // one-shot up from 3
        up_dn = 1'b1; one_shot = 1'b1;
        do_load(3);
        steps(1); chk("os_count4", int'(count), 4);
        steps(1); chk("os_count5", int'(count), 5);
        chk("os_tc_early", int'(tc), 0);
        steps(1);
        chk("os_hold", int'(count), 5);
        chk("os_tc", int'(tc), 1);
        chk("os_done", int'(done), 1);
        chk("os_running", int'(running), 0);
        steps(1);
        chk("os_hold2", int'(count), 5);
        chk("os_tc_once", int'(tc), 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_count", int'(count), 0);
        chk("restart_running", int'(running), 1);
        chk("restart_done", int'(done), 0);
        one_shot = 1'b0;

        // load clamp, then clear beating load and start
        do_load(7);
        chk("clamp", int'(count), 5);
        clear = 1'b1; load = 1'b1; load_val = 3'd3; start = 1'b1;
        cyc();
        clear = 1'b0; load = 1'b0; start = 1'b0;
        chk("clear_count", int'(count), RV);
        chk("clear_running", int'(running), 0);

        // async reset mid-cycle
        start = 1'b1; cyc(); start = 1'b0;
        do_load(3);
        chk("pre_rst", int'(count), 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_tc", int'(tc), 0);
        chk("arst_running", int'(running), 0);
        cyc();
        reset = 1'b0;
        cyc();

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = W'($urandom_range(0, 7));
            start    = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 15) == 0) one_shot = ~one_shot;
            cyc();
        end

        reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
